// File: rtl/booth_mult_pkg.sv
// ============================================================
// Module  : booth_mult_pkg
// Brief   : Shared multdiv widths and Booth multiplier states.
// Revision: 1.0
// ============================================================
`default_nettype none

package booth_mult_pkg;
    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = 32;
    localparam int PROD_WIDTH = 65;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================
// Module  : booth_step
// Brief   : One radix-2 Booth add/subtract and arithmetic shift.
// Revision: 1.0
// ============================================================
`default_nettype none

module booth_step
    import booth_mult_pkg::*;
(
    input  logic [PROD_WIDTH-1:0] p,
    input  logic [MULT_WIDTH-1:0] m,
    output logic [PROD_WIDTH-1:0] p_next
);

    logic [MULT_WIDTH:0] w_hi;
    logic [MULT_WIDTH:0] w_m;
    logic [MULT_WIDTH:0] w_sum;

    // 33-bit sum keeps M = 0x80000000 exact when negated.
    assign w_hi = {p[PROD_WIDTH-1], p[PROD_WIDTH-1:MULT_WIDTH+1]};
    assign w_m  = {m[MULT_WIDTH-1], m};

    always_comb begin
        w_sum = w_hi;
        case (p[1:0])
            2'b01:   w_sum = w_hi + w_m;
            2'b10:   w_sum = w_hi - w_m;
            default: w_sum = w_hi;
        endcase
    end

    assign p_next = {w_sum, p[MULT_WIDTH:1]};

endmodule

`default_nettype wire

// File: rtl/booth_mult.sv
// ============================================================
// Module  : booth_mult
// Brief   : Sequential 32x32 signed Booth multiplier with RDY strobe.
// Revision: 1.0
// ============================================================
`default_nettype none

module booth_mult
    import booth_mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ctrl_MULT,
    input  logic [MULT_WIDTH-1:0] data_operandA,
    input  logic [MULT_WIDTH-1:0] data_operandB,
    output logic [MULT_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY
);

    localparam logic [5:0] c_LAST_CNT = 6'(MULT_ITERS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [5:0]              r_cnt;
    logic [PROD_WIDTH-1:0]   r_p;
    logic [MULT_WIDTH-1:0]   r_m;
    logic [PROD_WIDTH-1:0]   w_p_next;
    logic                    w_load;
    logic                    w_step;
    logic [MULT_WIDTH-1:0]   r_result;
    logic                    r_exception;
    logic                    r_rdy;

    booth_step u_step (
        .p      (r_p),
        .m      (r_m),
        .p_next (w_p_next)
    );

    // A start in any state (re)loads; a start in BUSY abandons the current product.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (ctrl_MULT) begin
                    w_load       = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (ctrl_MULT) begin
                    w_load       = 1'b1;
                    w_state_next = BUSY;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == c_LAST_CNT) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (ctrl_MULT) begin
                    w_load       = 1'b1;
                    w_state_next = BUSY;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 6'd0;
            r_p         <= '0;
            r_m         <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rdy   <= (r_state == BUSY) && (w_state_next == DONE);
            if (w_load) begin
                r_m   <= data_operandA;
                r_p   <= {{MULT_WIDTH{1'b0}}, data_operandB, 1'b0};
                r_cnt <= 6'd0;
            end else if (w_step) begin
                r_p   <= w_p_next;
                r_cnt <= r_cnt + 6'd1;
            end
            // Result registers are only written on the final step and hold otherwise.
            if ((r_state == BUSY) && (w_state_next == DONE)) begin
                r_result    <= w_p_next[MULT_WIDTH:1];
                r_exception <= (w_p_next[PROD_WIDTH-1:MULT_WIDTH+1] != {MULT_WIDTH{w_p_next[MULT_WIDTH]}});
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = r_rdy;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult.sv
// ============================================================
// Module  : tb_booth_mult
// Brief   : Self-checking bench for booth_mult against a product model.
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_booth_mult;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_cmp  = 0;
    int n_fail = 0;

    booth_mult dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clk = ~clk;

    // Reference: full signed 64-bit product, low word plus fits-in-32 test.
    function automatic logic [32:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        longint prod;
        logic   ovf;
        prod = longint'($signed(a)) * longint'($signed(b));
        ovf  = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
        return {ovf, prod[31:0]};
    endfunction

    // Model timing: a start at edge E0 produces RDY after edge E0+32 unless a later start or reset intervenes.
    int          pending = -1;
    logic [31:0] op_a, op_b;
    logic [31:0] exp_res = '0;
    logic        exp_exc = 1'b0;
    logic        exp_rdy = 1'b0;
    logic [32:0] mres;

    always @(posedge clk) begin
        if (reset) begin
            pending = -1;
            exp_res = '0;
            exp_exc = 1'b0;
            exp_rdy = 1'b0;
        end else if (ctrl_MULT) begin
            pending = 32;
            op_a    = data_operandA;
            op_b    = data_operandB;
            exp_rdy = 1'b0;
        end else begin
            exp_rdy = 1'b0;
            if (pending > 0) begin
                pending = pending - 1;
                if (pending == 0) begin
                    mres    = model_mul(op_a, op_b);
                    exp_res = mres[31:0];
                    exp_exc = mres[32];
                    exp_rdy = 1'b1;
                    pending = -1;
                end
            end
        end
        #1;
        n_cmp++;
        if (data_resultRDY !== exp_rdy || data_result !== exp_res || data_exception !== exp_exc) begin
            n_fail++;
            $display("FAIL model t=%0t: rdy/res/exc got %b/%h/%b want %b/%h/%b",
                     $time, data_resultRDY, data_result, data_exception, exp_rdy, exp_res, exp_exc);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Directed multiply with hand-computed expectation and latency check.
    task automatic mul(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want_res, input logic want_exc);
        int lat;
        @(negedge clk);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                ctrl_MULT     = 1'b0;
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
            if (data_resultRDY === 1'b1) break;
        end
        check({name, " latency"}, 32'(lat), 32'd33);
        check({name, " result"}, data_result, want_res);
        check({name, " exception"}, {31'd0, data_exception}, {31'd0, want_exc});
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(negedge clk);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset result", data_result, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);

        mul("3x5", 32'd3, 32'd5, 32'h0000000F, 1'b0);
        mul("-7x6", 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 1'b0);
        mul("min x -1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        mul("min x 1", 32'h80000000, 32'h00000001, 32'h80000000, 1'b0);
        mul("2^16 sq", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);

        // Restart 10 cycles into 2x3; the original RDY must never appear.
        pulse_start(32'd2, 32'd3);
        repeat (9) @(negedge clk);
        mul("restart 4x4", 32'd4, 32'd4, 32'h00000010, 1'b0);

        // Reset mid-operation clears everything and suppresses RDY.
        pulse_start(32'd123, 32'd456);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid reset result", data_result, 32'd0);
        check("mid reset exc", {31'd0, data_exception}, 32'd0);
        check("mid reset rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (40) @(negedge clk);
        mul("9x9 after reset", 32'd9, 32'd9, 32'h00000051, 1'b0);

        // Random traffic: aborts, back-to-back starts in the DONE cycle, idle gaps.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case (k % 5)
                0: ra = {{16{ra[15]}}, ra[15:0]};
                1: rb = {{20{rb[11]}}, rb[11:0]};
                2: ra = (k % 2 == 0) ? 32'h80000000 : 32'h7FFFFFFF;
                default: ;
            endcase
            data_operandA = ra;
            data_operandB = rb;
            ctrl_MULT     = 1'b1;
            @(negedge clk);
            ctrl_MULT     = 1'b0;
            data_operandA = $urandom;
            data_operandB = $urandom;
            if (k % 7 == 3) begin
                repeat ($urandom_range(1, 31)) @(negedge clk);
            end else begin
                int j;
                for (j = 0; j < 40; j++) begin
                    if (data_resultRDY === 1'b1) break;
                    @(negedge clk);
                end
                if (j == 40) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL random rdy timeout: got 0 want 1 within 40 cycles");
                end
                if (k % 3 == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end

        repeat (40) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
